// File: rtl/max_bist.sv
// max_bist: self-checking stimulus engine for a WIDTH-bit MAX(A,B) comparator.
//
// On start it sweeps every operand pair (a-major, from (0,0)), holds each pair
// for SETTLE+1 cycles, samples max_in on the last edge of that window and
// compares it with an internal MAX reference built from the registered
// operands. Mismatches are counted, saturating at 255.
//
// Optional feature: define MAX_BIST_FAILLOG_EN to capture the first failing
// vector of each sweep on fail_a/fail_b/fail_got. Without it those outputs
// are constant 0 and no capture registers exist.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over start)
//   start      begins a sweep; looked at only in IDLE or DONE
//   a_out      operand i1 to the comparator (registered)
//   b_out      operand i2 to the comparator (registered)
//   max_in     comparator result
//   busy       high while the sweep runs
//   done       high in DONE until the next start or reset
//   pass       done && err_count == 0
//   err_count  mismatch count, saturating at 255
//   fail_a/fail_b/fail_got  first failing vector (FAILLOG builds only)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a level sampled on the rising edge; a sweep begins on
// any edge where start=1 and the FSM is in IDLE or DONE. There is no ready;
// start during RUN has no effect.
module max_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] max_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_got,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VW = 2 * WIDTH;
  // Settle counter needs at least one bit even when SETTLE is 0.
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [SW-1:0]   s_q, s_d;
  logic [7:0]      err_q, err_d;
  logic [WIDTH-1:0] expected;
  logic            mismatch;
  logic            clr;   // start accepted: wipe results
  logic            cap;   // first mismatch of this sweep

  assign a_out    = vec_q[VW-1:WIDTH];
  assign b_out    = vec_q[WIDTH-1:0];
  assign expected = (a_out > b_out) ? a_out : b_out;
  assign mismatch = (max_in != expected);

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 8'd0);
  assign err_count = err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      s_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      s_q     <= s_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    s_d     = s_q;
    err_d   = err_q;
    clr     = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          s_d     = '0;
          err_d   = '0;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (s_q != SETTLE_V) begin
          s_d = s_q + 1'b1;
        end else begin
          // Check edge: max_in has had SETTLE+1 cycles to settle.
          s_d = '0;
          if (mismatch) begin
            if (err_q != 8'hff) err_d = err_q + 8'd1;
            // err_q still zero means no earlier mismatch in this sweep.
            if (err_q == 8'd0) cap = 1'b1;
          end
          if (vec_q == '1) state_d = DONE;  // operands hold the last vector
          else             vec_d   = vec_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MAX_BIST_FAILLOG_EN
  logic [WIDTH-1:0] fa_q, fb_q, fg_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fa_q <= '0;
      fb_q <= '0;
      fg_q <= '0;
    end else if (cap) begin
      fa_q <= a_out;
      fb_q <= b_out;
      fg_q <= max_in;
    end
  end

  assign fail_a   = fa_q;
  assign fail_b   = fb_q;
  assign fail_got = fg_q;
`else
  assign fail_a   = '0;
  assign fail_b   = '0;
  assign fail_got = '0;
`endif

endmodule

// File: tb/tb_max_bist.sv
// Directed bench for max_bist: three instances (SETTLE=1, 0, 3) each driven
// by a small comparator model. The SETTLE=1 instance's model is switchable
// between correct MAX, MIN, stuck-at-0 and inverted MAX.
module tb_max_bist;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT (SETTLE=1) ----------------
  logic         start;
  logic [W-1:0] a_out, b_out, max_in, fail_a, fail_b, fail_got;
  logic         busy, done, pass;
  logic [7:0]   err_count;
  logic [1:0]   dbg_state;
  int           mode;  // 0 MAX, 1 MIN, 2 stuck 0, 3 inverted MAX

  max_bist #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
    .max_in(max_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b),
    .fail_got(fail_got), .dbg_state(dbg_state)
  );

  always_comb begin
    max_in = (a_out > b_out) ? a_out : b_out;
    case (mode)
      1:       max_in = (a_out < b_out) ? a_out : b_out;
      2:       max_in = '0;
      3:       max_in = ~((a_out > b_out) ? a_out : b_out);
      default: ;
    endcase
  end

  // ---------------- DUT (SETTLE=0) ----------------
  logic         start0, busy0, done0, pass0;
  logic [W-1:0] a0, b0, m0, fa0, fb0, fg0;
  logic [7:0]   err0;
  logic [1:0]   st0;
  assign m0 = (a0 > b0) ? a0 : b0;

  max_bist #(.WIDTH(W), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0),
    .max_in(m0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_a(fa0), .fail_b(fb0), .fail_got(fg0),
    .dbg_state(st0)
  );

  // ---------------- DUT (SETTLE=3) ----------------
  logic         start3, busy3, done3, pass3;
  logic [W-1:0] a3, b3, m3, fa3, fb3, fg3;
  logic [7:0]   err3;
  logic [1:0]   st3;
  assign m3 = (a3 > b3) ? a3 : b3;

  max_bist #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3),
    .max_in(m3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_a(fa3), .fail_b(fb3), .fail_got(fg3),
    .dbg_state(st3)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start on instance sel across exactly one rising edge.
  task automatic pulse_start(input int sel);
    case (sel)
      0:       start0 = 1'b1;
      3:       start3 = 1'b1;
      default: start  = 1'b1;
    endcase
    step(1);
    start0 = 1'b0;
    start3 = 1'b0;
    start  = 1'b0;
  endtask

  // Count edges until done of instance sel is seen, bounded.
  task automatic wait_done(input int sel, output int n);
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < 3000) begin
      step(1);
      n++;
      case (sel)
        0:       d = done0;
        3:       d = done3;
        default: d = done;
      endcase
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_a"},    32'(a_out), 0);
    chk({tag, "_b"},    32'(b_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"},  32'(err_count), 0);
    chk({tag, "_fa"},   32'(fail_a), 0);
    chk({tag, "_fb"},   32'(fail_b), 0);
    chk({tag, "_fg"},   32'(fail_got), 0);
    chk({tag, "_st"},   32'(dbg_state), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; start3 = 1'b0; mode = 0;
    step(3);
    chk_idle_zero("reset");
    rst = 1'b0;
    step(2);
    chk("idle_hold_busy", 32'(busy), 0);

    // Correct MAX model, default SETTLE.
    pulse_start(1);
    chk("start_busy", 32'(busy), 1);
    chk("start_vec_b", 32'(b_out), 0);
    step(2);  // one settle cycle + check edge moves to (0,1)
    chk("vec1_a", 32'(a_out), 0);
    chk("vec1_b", 32'(b_out), 1);
    wait_done(1, n);
    chk("max_cycles", 32'(n), 510);
    chk("max_pass", 32'(pass), 1);
    chk("max_err", 32'(err_count), 0);
    chk("max_busy", 32'(busy), 0);
    chk("max_a_hold", 32'(a_out), 15);
    chk("max_b_hold", 32'(b_out), 15);
    chk("max_state", 32'(dbg_state), 2);
    step(4);
    chk("done_sticky", 32'(done), 1);

    // MIN model; start from DONE also exercises restart-and-clear.
    mode = 1;
    pulse_start(1);
    chk("restart_done", 32'(done), 0);
    chk("restart_pass", 32'(pass), 0);
    chk("restart_err", 32'(err_count), 0);
    wait_done(1, n);
    chk("min_cycles", 32'(n), 512);
    chk("min_err", 32'(err_count), 240);
    chk("min_pass", 32'(pass), 0);
`ifdef MAX_BIST_FAILLOG_EN
    chk("min_fa", 32'(fail_a), 0);
    chk("min_fb", 32'(fail_b), 1);
    chk("min_fg", 32'(fail_got), 0);
`else
    chk("min_fa_off", 32'(fail_a), 0);
    chk("min_fb_off", 32'(fail_b), 0);
    chk("min_fg_off", 32'(fail_got), 0);
`endif

    // Stuck-at-0: exactly 255 mismatches.
    mode = 2;
    pulse_start(1);
    wait_done(1, n);
    chk("stuck_err", 32'(err_count), 255);
    chk("stuck_pass", 32'(pass), 0);

    // Inverted MAX: 256 mismatches, saturates at 255.
    mode = 3;
    pulse_start(1);
    wait_done(1, n);
    chk("inv_err_sat", 32'(err_count), 255);
`ifdef MAX_BIST_FAILLOG_EN
    chk("inv_fa", 32'(fail_a), 0);
    chk("inv_fb", 32'(fail_b), 0);
    chk("inv_fg", 32'(fail_got), 15);
`endif

    // Reset mid-sweep, then a clean sweep.
    mode = 1;
    pulse_start(1);
    step(100);
    rst = 1'b1;
    step(1);
    chk_idle_zero("midrst");
    rst = 1'b0;
    mode = 0;
    step(2);
    pulse_start(1);
    wait_done(1, n);
    chk("after_rst_cycles", 32'(n), 512);
    chk("after_rst_pass", 32'(pass), 1);

    // start held through RUN is ignored.
    start = 1'b1;
    step(1);
    wait_done(1, n);
    start = 1'b0;
    chk("hold_start_cycles", 32'(n), 512);
    chk("hold_start_pass", 32'(pass), 1);
    step(1);
    chk("hold_start_stays_done", 32'(done), 1);

    // SETTLE=0: 256 cycles.
    pulse_start(0);
    wait_done(0, n);
    chk("s0_cycles", 32'(n), 256);
    chk("s0_pass", 32'(pass0), 1);
    chk("s0_err", 32'(err0), 0);

    // SETTLE=3: 1024 cycles.
    pulse_start(3);
    wait_done(3, n);
    chk("s3_cycles", 32'(n), 1024);
    chk("s3_pass", 32'(pass3), 1);
    chk("s3_a_hold", 32'(a3), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/max_bist.md
# max_bist

Self-checking stimulus engine for the 4-bit MAX(A,B) comparator: drives the comparator's two operand inputs, samples its max output, and checks it against an internal reference. On `start` it sweeps all 2^(2·WIDTH) operand pairs, counts mismatches and reports pass/fail. It sits on the lab board next to the comparator so the operand/result interface can be exercised in hardware without a simulator testbench.

## Interface
- `WIDTH`, 4: operand width; the sweep covers all 2^(2·WIDTH) pairs.
- `SETTLE`, 1: extra cycles each vector is held before `max_in` is sampled (≥0).
- `clk`  input  1  single clock; everything is sampled on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begins a sweep; sampled only in IDLE or DONE.
- `a_out`  output  WIDTH  operand i1 to the comparator.
- `b_out`  output  WIDTH  operand i2 to the comparator.
- `max_in`  input  WIDTH  comparator result.
- `busy`  output  1  high while the sweep runs.
- `done`  output  1  high in DONE until the next start or reset.
- `pass`  output  1  `done && err_count==0`.
- `err_count`  output  8  mismatch count, saturating at 255.
- `fail_a`, `fail_b`, `fail_got`  output  WIDTH each  first failing vector; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- The vector counter `vec` is 2·WIDTH bits wide. `a_out = vec[2W-1:W]` and `b_out = vec[W-1:0]`, both registered. The order is a-major, starting at (0,0).
- Expected value: `(a_out > b_out) ? a_out : b_out`, unsigned, computed from the registered operands.
- IDLE/DONE, `start=1`: clear `vec`, settle counter `s` and `err_count`; set `busy=1`, `done=0`; go to RUN.
- RUN, `s < SETTLE`: `s <= s+1`; operands held.
- RUN, `s == SETTLE` (check edge):
  - Compare `max_in` with the expected value. On mismatch, `err_count <= min(err_count+1, 255)`.
  - `s <= 0`.
  - If `vec` is all ones: go to DONE, `busy=0`, `done=1`, and operands hold the last vector. Otherwise `vec <= vec+1`.
- `start` in RUN is ignored.
- `start` in DONE restarts the sweep and clears all results.
- `rst` at any point, including mid-sweep: state IDLE; all outputs 0 (`a_out`, `b_out`, `busy`, `done`, `pass`, `err_count`, `fail_*`).
- `rst` has priority over `start` in the same cycle.

## Timing
- Each vector is presented for SETTLE+1 cycles. `max_in` is sampled at the last rising edge of that window.
- A full sweep takes 2^(2·WIDTH)·(SETTLE+1) cycles after the start edge. With defaults this is 512 cycles.
- `done` rises on the edge following the final check.
- `pass` is combinational from `done` and `err_count`. It is 0 whenever `done=0`.
- With SETTLE=0 a new vector is presented every cycle. The comparator must then be combinational with single-cycle settling.
- Saturation: `err_count` stays at 255 once reached; the 256th mismatch does not wrap it.

## Configuration
- `MAX_BIST_FAILLOG_EN` defined:
  - On the first mismatch of a sweep, `fail_a`, `fail_b` and `fail_got` capture `a_out`, `b_out` and `max_in`.
  - Later mismatches do not overwrite them.
  - They are cleared on start and on reset.
- `MAX_BIST_FAILLOG_EN` undefined: `fail_a`, `fail_b` and `fail_got` are constant 0 and no capture registers are built.

## Test plan
- Correct MAX model, defaults, start pulse at cycle 5 -> `busy` high for 512 cycles, then `done=1`, `pass=1`, `err_count=0`, operands held at (1111,1111).
- MIN model instead of MAX -> `err_count=240` (all a≠b pairs) and `pass=0`. With FAILLOG: `fail_a=0000`, `fail_b=0001`, `fail_got=0000`.
- `max_in` stuck at 0 -> `err_count=255` (every pair except (0,0)). Bitwise-inverted MAX -> 256 mismatches, `err_count` saturates at 255 and does not wrap.
- Reset pulse at cycle 100 of a sweep -> next cycle shows IDLE with every output 0. A fresh start then completes with a correct model: `pass=1`.
- `start` held high throughout RUN -> no restart; `done` at exactly 512 cycles. Start asserted in DONE -> results clear and a new 512-cycle sweep begins.
- SETTLE=0 with a correct model -> sweep finishes in 256 cycles with `pass=1`. SETTLE=3 -> 1024 cycles.
